// File: rtl/card_lock_pkg.sv
// Shared types and constants for the card lock front end: FSM state encoding,
// card type codes and the serial frame length.
package card_lock_pkg;

    localparam int FRAME_BITS = 19;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SHIFT       = 3'd1,
        ST_CHECK       = 3'd2,
        ST_PRESENT     = 3'd3,
        ST_UNLOCK      = 3'd4,
        ST_REJECT      = 3'd5,
        ST_WAIT_REMOVE = 3'd6,
        ST_LOCKOUT     = 3'd7
    } state_e;

    localparam logic [1:0] CARD_GUEST     = 2'b00;
    localparam logic [1:0] CARD_MAID      = 2'b01;
    localparam logic [1:0] CARD_GUEST_RST = 2'b10;
    localparam logic [1:0] CARD_MAID_RST  = 2'b11;

    // A frame is accepted when its total count of ones is even.
    function automatic logic frame_parity_ok(input logic [FRAME_BITS-1:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/card_frame_rx.sv
// Serial frame receiver: shifts in card bits MSB first, counts them, watches
// the inter-bit gap and reports done/ok/timeout to the sequencer FSM.
module card_frame_rx
    import card_lock_pkg::*;
#(
    parameter int BIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        bit_i,
    input  logic        bit_valid_i,
    output logic        done_o,
    output logic        ok_o,
    output logic        timeout_o,
    output logic [1:0]  type_o,
    output logic [15:0] code_o
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(BIT_TIMEOUT + 1);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         gap_q, gap_d;

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
            gap_d   = '0;
        end else if (enable_i) begin
            if (bit_valid_i) begin
                shift_d = {shift_q[FRAME_BITS-2:0], bit_i};
                cnt_d   = cnt_q + 1'b1;
                gap_d   = '0;
                done_o  = (cnt_q == CW'(FRAME_BITS - 1));
            end else if (cnt_q != '0) begin
                // The gap timer only runs once the first bit has been seen.
                if (gap_q == TW'(BIT_TIMEOUT - 1)) begin
                    timeout_o = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        end
    end

    // Fields are taken from the next-state word so the sequencer can load
    // them on the same edge the last bit arrives.
    assign ok_o   = frame_parity_ok(shift_d);
    assign type_o = shift_d[FRAME_BITS-1:FRAME_BITS-2];
    assign code_o = shift_d[FRAME_BITS-3:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: rtl/card_read_sequencer.sv
// Card lock front end: receives and checks a card frame, presents it to the
// lock, drives the door on a trip and locks the reader out after repeated fails.
module card_read_sequencer
    import card_lock_pkg::*;
#(
    parameter int UNLOCK_CYCLES  = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int BIT_TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             card_present,
    input  logic                             card_bit,
    input  logic                             card_bit_valid,
    input  logic                             lock_tripped,
    output logic [1:0]                       card_type,
    output logic [15:0]                      entry_code,
    output logic                             card_read,
    output logic                             door_unlock,
    output logic                             reader_busy,
    output logic                             frame_error,
    output logic                             lockout,
    output logic [2:0]                       dbg_state,
    output logic [$clog2(MAX_FAILS+1)-1:0]   dbg_fail_count
);

    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                          ((UNLOCK_CYCLES > 2) ? UNLOCK_CYCLES : 2) :
                          ((LOCKOUT_CYCLES > 2) ? LOCKOUT_CYCLES : 2);
    localparam int TW   = $clog2(TMAX + 1);

    state_e        state_q, state_d;
    logic          present_q;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          ok_q, ok_d;
    logic [1:0]    type_q, type_d;
    logic [15:0]   code_q, code_d;
    logic          ferr_d;
    logic          read_q, door_q, busy_q, ferr_q, lock_q;

    logic          rx_done, rx_ok, rx_timeout;
    logic [1:0]    rx_type;
    logic [15:0]   rx_code;

    card_frame_rx #(
        .BIT_TIMEOUT (BIT_TIMEOUT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (state_q == ST_IDLE),
        .enable_i    (state_q == ST_SHIFT),
        .bit_i       (card_bit),
        .bit_valid_i (card_bit_valid),
        .done_o      (rx_done),
        .ok_o        (rx_ok),
        .timeout_o   (rx_timeout),
        .type_o      (rx_type),
        .code_o      (rx_code)
    );

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        ok_d    = ok_q;
        type_d  = type_q;
        code_d  = code_q;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (card_present && !present_q) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!card_present) begin
                    state_d = ST_REJECT;
                end else if (rx_timeout) begin
                    state_d = ST_REJECT;
                    ferr_d  = 1'b1;
                end else if (rx_done) begin
                    // Load the fields on entry to CHECK so they are stable a
                    // full cycle before card_read rises.
                    state_d = ST_CHECK;
                    ok_d    = rx_ok;
                    if (rx_ok) begin
                        type_d = rx_type;
                        code_d = rx_code;
                    end
                end
            end
            ST_CHECK: begin
                if (ok_q) begin
                    state_d = ST_PRESENT;
                end else begin
                    state_d = ST_REJECT;
                    ferr_d  = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (tmr_q == TW'(1)) state_d = lock_tripped ? ST_UNLOCK : ST_REJECT;
            end
            ST_UNLOCK: begin
                if (tmr_q == TW'(UNLOCK_CYCLES - 1)) begin
                    fail_d  = '0;
                    state_d = ST_WAIT_REMOVE;
                end
            end
            ST_REJECT: begin
                if (fail_q != FW'(MAX_FAILS)) fail_d = fail_q + 1'b1;
                state_d = (fail_q >= FW'(MAX_FAILS - 1)) ? ST_LOCKOUT : ST_WAIT_REMOVE;
            end
            ST_WAIT_REMOVE: begin
                if (!card_present) state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (tmr_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    fail_d  = '0;
                    state_d = ST_WAIT_REMOVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // One shared timer, restarted on every state change.
        tmr_d = (state_d != state_q) ? '0 : tmr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            present_q <= 1'b0;
            fail_q    <= '0;
            tmr_q     <= '0;
            ok_q      <= 1'b0;
            type_q    <= '0;
            code_q    <= '0;
            read_q    <= 1'b0;
            door_q    <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            present_q <= card_present;
            fail_q    <= fail_d;
            tmr_q     <= tmr_d;
            ok_q      <= ok_d;
            type_q    <= type_d;
            code_q    <= code_d;
            read_q    <= (state_d == ST_PRESENT);
            door_q    <= (state_d == ST_UNLOCK);
            busy_q    <= (state_d != ST_IDLE);
            ferr_q    <= ferr_d;
            lock_q    <= (state_d == ST_LOCKOUT);
        end
    end

    assign card_type      = type_q;
    assign entry_code     = code_q;
    assign card_read      = read_q;
    assign door_unlock    = door_q;
    assign reader_busy    = busy_q;
    assign frame_error    = ferr_q;
    assign lockout        = lock_q;
    assign dbg_state      = state_q;
    assign dbg_fail_count = fail_q;

endmodule

// File: tb/tb_card_read_sequencer.sv
// Directed bench for card_read_sequencer: drives frames at the falling edge
// and checks outputs there against hand-derived expectations.
module tb_card_read_sequencer;

    localparam int S_IDLE    = 0;
    localparam int S_SHIFT   = 1;
    localparam int S_CHECK   = 2;
    localparam int S_PRESENT = 3;
    localparam int S_UNLOCK  = 4;
    localparam int S_REJECT  = 5;
    localparam int S_WAIT    = 6;
    localparam int S_LOCKOUT = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        card_present = 1'b0;
    logic        card_bit = 1'b0;
    logic        card_bit_valid = 1'b0;
    logic        lock_tripped = 1'b0;
    logic [1:0]  card_type;
    logic [15:0] entry_code;
    logic        card_read;
    logic        door_unlock;
    logic        reader_busy;
    logic        frame_error;
    logic        lockout;
    logic [2:0]  dbg_state;
    logic [1:0]  dbg_fail_count;

    int checks = 0;
    int failures = 0;

    card_read_sequencer #(
        .UNLOCK_CYCLES  (8),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (64),
        .BIT_TIMEOUT    (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .card_present   (card_present),
        .card_bit       (card_bit),
        .card_bit_valid (card_bit_valid),
        .lock_tripped   (lock_tripped),
        .card_type      (card_type),
        .entry_code     (entry_code),
        .card_read      (card_read),
        .door_unlock    (door_unlock),
        .reader_busy    (reader_busy),
        .frame_error    (frame_error),
        .lockout        (lockout),
        .dbg_state      (dbg_state),
        .dbg_fail_count (dbg_fail_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] make_frame(input logic [1:0] t, input logic [15:0] c);
        return {t, c, ^{t, c}};
    endfunction

    // drivers
    task automatic insert_card();
        card_present = 1'b1;
        @(negedge clk);
        chk("insert_state", dbg_state, S_SHIFT);
        chk("insert_busy", reader_busy, 1);
    endtask

    task automatic send_bits(input logic [18:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            card_bit_valid = 1'b1;
            card_bit       = w[18-i];
            @(negedge clk);
        end
        card_bit_valid = 1'b0;
        card_bit       = 1'b0;
    endtask

    // Called in the CHECK cycle; lock_tripped is driven separately per cycle.
    task automatic present_phase(input logic trip1, input logic trip2);
        @(negedge clk);
        chk("present_c1_state", dbg_state, S_PRESENT);
        chk("present_c1_read", card_read, 1);
        lock_tripped = trip1;
        @(negedge clk);
        chk("present_c2_read", card_read, 1);
        lock_tripped = trip2;
        @(negedge clk);
        lock_tripped = 1'b0;
        chk("present_exit_state", dbg_state, trip2 ? S_UNLOCK : S_REJECT);
        chk("present_exit_read", card_read, 0);
    endtask

    task automatic wait_unlock(input string tag);
        int n;
        n = 0;
        while (door_unlock && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(tag, n, 8);
    endtask

    task automatic remove_card();
        card_present = 1'b0;
        @(negedge clk);
        chk("remove_state", dbg_state, S_IDLE);
        chk("remove_busy", reader_busy, 0);
    endtask

    task automatic good_card(input logic [1:0] t, input logic [15:0] c, input string tag);
        logic [18:0] w;
        w = make_frame(t, c);
        insert_card();
        send_bits(w, 19);
        chk({tag, "_check_state"}, dbg_state, S_CHECK);
        chk({tag, "_check_type"}, card_type, t);
        chk({tag, "_check_code"}, entry_code, c);
        chk({tag, "_check_read"}, card_read, 0);
    endtask

    initial begin
        logic [18:0] w;
        int n;
        logic rd_seen;

        // reset block
        repeat (3) @(negedge clk);
        chk("rst_type", card_type, 0);
        chk("rst_code", entry_code, 0);
        chk("rst_read", card_read, 0);
        chk("rst_door", door_unlock, 0);
        chk("rst_busy", reader_busy, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_lockout", lockout, 0);
        chk("rst_state", dbg_state, S_IDLE);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_state", dbg_state, S_IDLE);

        // 1: good guest card 0xACE1, lock trips in the 2nd PRESENT cycle
        good_card(2'b00, 16'hACE1, "guest");
        present_phase(1'b0, 1'b1);
        chk("guest_door", door_unlock, 1);
        wait_unlock("guest_unlock_len");
        chk("guest_after_state", dbg_state, S_WAIT);
        chk("guest_fails", dbg_fail_count, 0);
        remove_card();

        // 2: same frame with one bit flipped -> parity error
        w = make_frame(2'b00, 16'hACE1) ^ 19'h00020;
        insert_card();
        send_bits(w, 19);
        chk("bad_check_state", dbg_state, S_CHECK);
        chk("bad_code_hold", entry_code, 16'hACE1);
        @(negedge clk);
        chk("bad_reject_state", dbg_state, S_REJECT);
        chk("bad_ferr", frame_error, 1);
        chk("bad_no_read", card_read, 0);
        @(negedge clk);
        chk("bad_ferr_pulse", frame_error, 0);
        chk("bad_fails", dbg_fail_count, 1);
        chk("bad_wait", dbg_state, S_WAIT);
        remove_card();

        // 3: maid card, lock high only in 1st PRESENT cycle -> not a trip
        good_card(2'b01, 16'h1234, "maid");
        present_phase(1'b1, 1'b0);
        chk("maid_no_door", door_unlock, 0);
        @(negedge clk);
        chk("maid_fails", dbg_fail_count, 2);
        remove_card();

        // 4: success after two fails clears the counter; removal mid-unlock
        good_card(2'b00, 16'h0F0F, "clear");
        present_phase(1'b0, 1'b1);
        card_present = 1'b0;
        wait_unlock("clear_unlock_len");
        chk("clear_fails", dbg_fail_count, 0);
        chk("clear_wait", dbg_state, S_WAIT);
        @(negedge clk);
        chk("clear_idle", dbg_state, S_IDLE);

        // 5: stall after bit 7 -> timeout after 16 idle cycles
        w = make_frame(2'b00, 16'h5A5A);
        insert_card();
        send_bits(w, 7);
        repeat (15) @(negedge clk);
        chk("stall_still_shift", dbg_state, S_SHIFT);
        @(negedge clk);
        chk("stall_reject", dbg_state, S_REJECT);
        chk("stall_ferr", frame_error, 1);
        @(negedge clk);
        chk("stall_fails", dbg_fail_count, 1);
        remove_card();

        // 6: card pulled mid-frame -> reject without frame_error, back to idle
        insert_card();
        send_bits(w, 10);
        card_present = 1'b0;
        @(negedge clk);
        chk("pull_reject", dbg_state, S_REJECT);
        chk("pull_no_ferr", frame_error, 0);
        @(negedge clk);
        chk("pull_fails", dbg_fail_count, 2);
        chk("pull_no_lockout", lockout, 0);
        @(negedge clk);
        chk("pull_idle", dbg_state, S_IDLE);

        // 7: clear again, then three untripped cards -> lockout
        good_card(2'b00, 16'hBEEF, "clear2");
        present_phase(1'b0, 1'b1);
        wait_unlock("clear2_unlock_len");
        chk("clear2_fails", dbg_fail_count, 0);
        remove_card();

        good_card(2'b00, 16'h0001, "nt1");
        present_phase(1'b0, 1'b0);
        @(negedge clk);
        remove_card();
        good_card(2'b11, 16'hFFFF, "nt2");
        present_phase(1'b0, 1'b0);
        @(negedge clk);
        remove_card();
        good_card(2'b10, 16'h5555, "nt3");
        present_phase(1'b0, 1'b0);
        @(negedge clk);
        chk("lockout_state", dbg_state, S_LOCKOUT);
        chk("lockout_fails", dbg_fail_count, 3);

        // Fourth card pulled and reinserted during lockout must be ignored.
        w = make_frame(2'b00, 16'hACE1);
        lock_tripped = 1'b1;
        n = 0;
        rd_seen = 1'b0;
        while (lockout && n < 100) begin
            n++;
            if (n == 1) card_present = 1'b0;
            if (n == 4) card_present = 1'b1;
            card_bit_valid = (n >= 6 && n < 25);
            card_bit = (n >= 6 && n < 25) ? w[24-n] : 1'b0;
            @(negedge clk);
            if (card_read) rd_seen = 1'b1;
        end
        card_bit_valid = 1'b0;
        lock_tripped = 1'b0;
        chk("lockout_len", n, 64);
        chk("lockout_no_read", rd_seen, 0);
        chk("lockout_exit_state", dbg_state, S_WAIT);
        chk("lockout_exit_fails", dbg_fail_count, 0);
        remove_card();

        // 8: reset in the 3rd UNLOCK cycle aborts immediately
        good_card(2'b01, 16'hC0DE, "rst");
        present_phase(1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_door", door_unlock, 1);
        reset = 1'b1;
        card_present = 1'b0;
        @(negedge clk);
        chk("rst_mid_door_low", door_unlock, 0);
        chk("rst_mid_state", dbg_state, S_IDLE);
        chk("rst_mid_type", card_type, 0);
        chk("rst_mid_code", entry_code, 0);
        chk("rst_mid_busy", reader_busy, 0);
        chk("rst_mid_read", card_read, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", dbg_state, S_IDLE);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
